// File: rtl/bcd_date_counter.sv
// BCD calendar register (YYYY-MM-DD) advancing one day per adv strobe, with a validated parallel load.
// Optional day-of-week tracking is enabled by defining DATE_DAY_OF_WEEK_EN.
module bcd_date_counter #(
  parameter logic [15:0] RST_YEAR  = 16'h2000,
  parameter logic [7:0]  RST_MONTH = 8'h01,
  parameter logic [7:0]  RST_DAY   = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv,
  input  logic        ld,
  input  logic [15:0] ld_year,
  input  logic [7:0]  ld_month,
  input  logic [7:0]  ld_day,
  input  logic        ld_ly,
  input  logic        LY,
`ifdef DATE_DAY_OF_WEEK_EN
  input  logic [2:0]  ld_dow,
  output logic [2:0]  DOW,
`endif
  output logic [3:0]  YM,
  output logic [3:0]  YH,
  output logic [3:0]  YT,
  output logic [3:0]  YO,
  output logic [3:0]  MT,
  output logic [3:0]  MO,
  output logic [3:0]  DT,
  output logic [3:0]  DO,
  output logic        ld_err,
  output logic        yr_wrap
);

  typedef enum logic [1:0] {DAY_INC, MON_INC, YR_INC} carry_e;

  logic [15:0] year_q, year_d;
  logic [7:0]  month_q, month_d;
  logic [7:0]  day_q, day_d;
  logic        ld_err_q, ld_err_d;
  logic        yr_wrap_q, yr_wrap_d;
  carry_e      stage;
  logic        ld_ok;
  logic        digits_ok;
  logic        yr_carry;

  function automatic logic [7:0] max_day(input logic [7:0] month, input logic leap);
    case (month)
      8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: max_day = 8'h31;
      8'h04, 8'h06, 8'h09, 8'h11:                      max_day = 8'h30;
      8'h02:                                           max_day = leap ? 8'h29 : 8'h28;
      default:                                         max_day = 8'h31;
    endcase
  endfunction

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd2_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd2_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

`ifdef DATE_DAY_OF_WEEK_EN
  logic [2:0] dow_q, dow_d;
  assign DOW = dow_q;
`endif

  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ld_year[i*4 +: 4] > 4'd9) digits_ok = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (ld_month[i*4 +: 4] > 4'd9 || ld_day[i*4 +: 4] > 4'd9) digits_ok = 1'b0;
    end
    // With all digits valid, packed BCD compares in the same order as the decimal values.
    ld_ok = digits_ok
         && ld_month >= 8'h01 && ld_month <= 8'h12
         && ld_day >= 8'h01 && ld_day <= max_day(ld_month, ld_ly);
`ifdef DATE_DAY_OF_WEEK_EN
    if (ld_dow == 3'd7) ld_ok = 1'b0;
`endif
  end

  // Carry sequencer: how far the carry propagates on this advance.
  always_comb begin
    if (day_q != max_day(month_q, LY)) stage = DAY_INC;
    else if (month_q != 8'h12)         stage = MON_INC;
    else                               stage = YR_INC;
  end

  always_comb begin
    year_d    = year_q;
    month_d   = month_q;
    day_d     = day_q;
    ld_err_d  = 1'b0;
    yr_wrap_d = 1'b0;
    yr_carry  = 1'b1;
`ifdef DATE_DAY_OF_WEEK_EN
    dow_d = dow_q;
`endif
    if (ld) begin
      if (ld_ok) begin
        year_d  = ld_year;
        month_d = ld_month;
        day_d   = ld_day;
`ifdef DATE_DAY_OF_WEEK_EN
        dow_d   = ld_dow;
`endif
      end else begin
        ld_err_d = 1'b1;
      end
    end else if (adv) begin
`ifdef DATE_DAY_OF_WEEK_EN
      dow_d = (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
`endif
      case (stage)
        DAY_INC: day_d = bcd2_inc(day_q);
        MON_INC: begin
          day_d   = 8'h01;
          month_d = bcd2_inc(month_q);
        end
        YR_INC: begin
          day_d   = 8'h01;
          month_d = 8'h01;
          for (int i = 0; i < 4; i++) begin
            if (yr_carry) begin
              if (year_q[i*4 +: 4] == 4'd9) begin
                year_d[i*4 +: 4] = 4'd0;
              end else begin
                year_d[i*4 +: 4] = year_q[i*4 +: 4] + 4'd1;
                yr_carry = 1'b0;
              end
            end
          end
          yr_wrap_d = yr_carry;
        end
        default: day_d = day_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      year_q    <= RST_YEAR;
      month_q   <= RST_MONTH;
      day_q     <= RST_DAY;
      ld_err_q  <= 1'b0;
      yr_wrap_q <= 1'b0;
`ifdef DATE_DAY_OF_WEEK_EN
      dow_q     <= 3'd6;
`endif
    end else begin
      year_q    <= year_d;
      month_q   <= month_d;
      day_q     <= day_d;
      ld_err_q  <= ld_err_d;
      yr_wrap_q <= yr_wrap_d;
`ifdef DATE_DAY_OF_WEEK_EN
      dow_q     <= dow_d;
`endif
    end
  end

  assign {YM, YH, YT, YO} = year_q;
  assign {MT, MO}         = month_q;
  assign {DT, DO}         = day_q;
  assign ld_err           = ld_err_q;
  assign yr_wrap          = yr_wrap_q;

endmodule

// File: tb/tb_bcd_date_counter.sv
// Directed bench for bcd_date_counter: an integer calendar model pushes expectations to a
// scoreboard queue as each step is driven; they are popped and checked after the clock edge.
module tb_bcd_date_counter;

  logic        clk = 1'b0;
  logic        reset, adv, ld, ld_ly, LY;
  logic [15:0] ld_year;
  logic [7:0]  ld_month, ld_day;
  logic [3:0]  YM, YH, YT, YO, MT, MO, DT, DO;
  logic        ld_err, yr_wrap;
`ifdef DATE_DAY_OF_WEEK_EN
  logic [2:0]  ld_dow, DOW;
`endif

  typedef struct packed {
    logic [31:0] date;
    logic        err;
    logic        wrap;
    logic [2:0]  dow;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_year, m_month, m_day, m_dow;

  always #5 clk = ~clk;

  bcd_date_counter dut (
    .clk(clk), .reset(reset), .adv(adv), .ld(ld),
    .ld_year(ld_year), .ld_month(ld_month), .ld_day(ld_day), .ld_ly(ld_ly), .LY(LY),
`ifdef DATE_DAY_OF_WEEK_EN
    .ld_dow(ld_dow), .DOW(DOW),
`endif
    .YM(YM), .YH(YH), .YT(YT), .YO(YO), .MT(MT), .MO(MO), .DT(DT), .DO(DO),
    .ld_err(ld_err), .yr_wrap(yr_wrap)
  );

  function automatic int bcd2int(input logic [15:0] v);
    return 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic is_leap(input int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int dim(input int mon, input logic leap);
    if (mon == 2) return leap ? 29 : 28;
    if (mon == 4 || mon == 6 || mon == 9 || mon == 11) return 30;
    return 31;
  endfunction

  function automatic logic nibbles_ok(input logic [31:0] v);
    for (int i = 0; i < 8; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Stands in for the external LeapYear stage watching the year outputs.
  always_comb LY = is_leap(bcd2int({YM, YH, YT, YO}));

  task automatic apply(input string tag, input logic r, input logic a, input logic l,
                       input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d);
    exp_t e;
    logic valid;
    reset = r; adv = a; ld = l;
    ld_year = y; ld_month = mo; ld_day = d;
    ld_ly = nibbles_ok({y, mo, d}) && is_leap(bcd2int(y));
    e.err = 1'b0;
    e.wrap = 1'b0;
    if (r) begin
      m_year = 2000; m_month = 1; m_day = 1; m_dow = 6;
    end else if (l) begin
      valid = nibbles_ok({y, mo, d});
      if (valid) begin
        valid = bcd2int({8'h00, mo}) >= 1 && bcd2int({8'h00, mo}) <= 12 &&
                bcd2int({8'h00, d}) >= 1 &&
                bcd2int({8'h00, d}) <= dim(bcd2int({8'h00, mo}), is_leap(bcd2int(y)));
      end
`ifdef DATE_DAY_OF_WEEK_EN
      if (ld_dow == 3'd7) valid = 1'b0;
`endif
      if (valid) begin
        m_year = bcd2int(y); m_month = bcd2int({8'h00, mo}); m_day = bcd2int({8'h00, d});
`ifdef DATE_DAY_OF_WEEK_EN
        m_dow = int'(ld_dow);
`endif
      end else begin
        e.err = 1'b1;
      end
    end else if (a) begin
      m_dow = (m_dow + 1) % 7;
      m_day++;
      if (m_day > dim(m_month, is_leap(m_year))) begin
        m_day = 1;
        m_month++;
        if (m_month > 12) begin
          m_month = 1;
          m_year++;
          if (m_year > 9999) begin
            m_year = 0;
            e.wrap = 1'b1;
          end
        end
      end
    end
    e.date = {int2bcd(m_year), int2bcd(m_month)[7:0], int2bcd(m_day)[7:0]};
    e.dow = 3'(m_dow);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    vectors++;
    assert ({YM, YH, YT, YO, MT, MO, DT, DO} === e.date)
      else begin miscompares++; $error("FAIL %s date: got %h expected %h", tag, {YM, YH, YT, YO, MT, MO, DT, DO}, e.date); end
    vectors++;
    assert (ld_err === e.err)
      else begin miscompares++; $error("FAIL %s ld_err: got %b expected %b", tag, ld_err, e.err); end
    vectors++;
    assert (yr_wrap === e.wrap)
      else begin miscompares++; $error("FAIL %s yr_wrap: got %b expected %b", tag, yr_wrap, e.wrap); end
`ifdef DATE_DAY_OF_WEEK_EN
    vectors++;
    assert (DOW === e.dow)
      else begin miscompares++; $error("FAIL %s DOW: got %0d expected %0d", tag, DOW, e.dow); end
`endif
    $display("step %-12s date=%h ld_err=%b yr_wrap=%b", tag, {YM, YH, YT, YO, MT, MO, DT, DO}, ld_err, yr_wrap);
  endtask

  initial begin
    reset = 1'b1; adv = 1'b0; ld = 1'b0; ld_ly = 1'b0;
    ld_year = 16'h0; ld_month = 8'h0; ld_day = 8'h0;
`ifdef DATE_DAY_OF_WEEK_EN
    ld_dow = 3'd0;
`endif
    m_year = 2000; m_month = 1; m_day = 1; m_dow = 6;
    #2;
    apply("reset", 1, 0, 0, 16'h0000, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) apply("hold", 0, 0, 0, 16'h0000, 8'h00, 8'h00);

    apply("ld_leap", 0, 0, 1, 16'h2000, 8'h02, 8'h28);
    apply("adv_feb29", 0, 1, 0, 16'h0000, 8'h00, 8'h00);
    apply("adv_mar01", 0, 1, 0, 16'h0000, 8'h00, 8'h00);
    apply("ld_1900", 0, 0, 1, 16'h1900, 8'h02, 8'h28);
    apply("adv_1900", 0, 1, 0, 16'h0000, 8'h00, 8'h00);
    apply("ld_2023", 0, 0, 1, 16'h2023, 8'h12, 8'h31);
    apply("adv_newyr", 0, 1, 0, 16'h0000, 8'h00, 8'h00);
    apply("ld_9999", 0, 0, 1, 16'h9999, 8'h12, 8'h31);
    apply("adv_wrap", 0, 1, 0, 16'h0000, 8'h00, 8'h00);
    apply("post_wrap", 0, 0, 0, 16'h0000, 8'h00, 8'h00);
    apply("ld_0909", 0, 0, 1, 16'h2019, 8'h09, 8'h09);
    apply("adv_day10", 0, 1, 0, 16'h0000, 8'h00, 8'h00);

    apply("rej_feb29", 0, 0, 1, 16'h2023, 8'h02, 8'h29);
    apply("rej_mon13", 0, 0, 1, 16'h2023, 8'h13, 8'h01);
    apply("rej_day00", 0, 0, 1, 16'h2023, 8'h05, 8'h00);
    apply("rej_digA", 0, 0, 1, 16'h2023, 8'h05, 8'h1A);
    apply("rej_apr31", 0, 0, 1, 16'h2024, 8'h04, 8'h31);
    apply("post_rej", 0, 0, 0, 16'h0000, 8'h00, 8'h00);

    apply("ld_adv", 0, 1, 1, 16'h2001, 8'h06, 8'h15);
    apply("rst_ld", 1, 0, 1, 16'h2001, 8'h06, 8'h15);

`ifdef DATE_DAY_OF_WEEK_EN
    for (int i = 0; i < 8; i++) apply("dow_adv", 0, 1, 0, 16'h0000, 8'h00, 8'h00);
    ld_dow = 3'd7;
    apply("rej_dow7", 0, 0, 1, 16'h2001, 8'h06, 8'h15);
    ld_dow = 3'd3;
    apply("ld_dow3", 0, 0, 1, 16'h2001, 8'h06, 8'h15);
    apply("dow_adv2", 0, 1, 0, 16'h0000, 8'h00, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
